// File: rtl/page_bridge_pkg.sv
// Shared types and helpers for the page stream bridge: the start sequencer
// state encoding and the slice-offset helper used to address flattened buses.
package page_bridge_pkg;

  // Start sequencer states: HOLD for one cycle after reset, WAIT while the
  // start delay elapses, RUN once the kernel has been started.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } start_state_e;

  // Low bit of channel idx inside a flattened bus of width-bit lanes.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Single-clock valid/ready FIFO. The read port is combinational from the
// storage array, so the head word is valid in the same cycle as out_vld.
// A word written in cycle t becomes visible at the output in cycle t+1.
// in_ack and out_vld depend only on the registered occupancy.
module stream_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_ack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_OCC = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   occ_reg;

  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;

  // The extra occupancy bit separates full from empty when the pointers meet.
  assign full     = (occ_reg == FULL_OCC);
  assign empty    = (occ_reg == '0);
  assign in_ack   = ~full;
  assign out_vld  = ~empty;
  // A write into a full FIFO is refused even if a read frees a slot that cycle.
  assign wr_en    = in_vld & ~full;
  assign rd_en    = out_ack & ~empty;
  assign out_data = mem_reg[rd_ptr_reg];

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo the depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: rtl/page_stream_bridge.sv
// Elastic multi-channel bridge between the leaf interface and the user kernel.
// Each direction has one FIFO per channel. A start sequencer holds the kernel
// side closed until ap_start rises; the leaf side may fill the input FIFOs
// meanwhile. Per-channel transfer counters and an ap_done counter are kept,
// and all of them are cleared by a resend pulse.
module page_stream_bridge
  import page_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_IN_PORTS    = 2,
  parameter int NUM_OUT_PORTS   = 2,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int START_DELAY     = 16,
  parameter int CNT_BITS        = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  resend,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  if_dout,
  input  logic [NUM_IN_PORTS-1:0]               if_vld,
  output logic [NUM_IN_PORTS-1:0]               if_ack,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  usr_din,
  output logic [NUM_IN_PORTS-1:0]               usr_vld,
  input  logic [NUM_IN_PORTS-1:0]               usr_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] usr_dout,
  input  logic [NUM_OUT_PORTS-1:0]              usr_out_vld,
  output logic [NUM_OUT_PORTS-1:0]              usr_out_ack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] if_din,
  output logic [NUM_OUT_PORTS-1:0]              if_out_vld,
  input  logic [NUM_OUT_PORTS-1:0]              if_out_ack,
  output logic                                  ap_start,
  input  logic                                  ap_done,
  output logic [NUM_IN_PORTS*CNT_BITS-1:0]      in_cnt,
  output logic [NUM_OUT_PORTS*CNT_BITS-1:0]     out_cnt,
  output logic [CNT_BITS-1:0]                   done_cnt
);

  localparam int WAIT_BITS = $clog2(START_DELAY + 1);

  start_state_e         state_reg;
  logic [WAIT_BITS-1:0] wait_cnt_reg;
  logic                 ap_start_reg;

  // leaf_open keeps if_ack low in reset and during the HOLD cycle;
  // kernel_open gates the kernel-facing handshakes until the kernel runs.
  logic leaf_open;
  logic kernel_open;

  logic [NUM_IN_PORTS-1:0]  in_fifo_ack;
  logic [NUM_IN_PORTS-1:0]  in_fifo_vld;
  logic [NUM_OUT_PORTS-1:0] out_fifo_ack;

  logic [CNT_BITS-1:0] in_cnt_reg  [NUM_IN_PORTS];
  logic [CNT_BITS-1:0] out_cnt_reg [NUM_OUT_PORTS];
  logic [CNT_BITS-1:0] done_cnt_reg;

  assign leaf_open   = (state_reg != HOLD);
  assign kernel_open = ap_start_reg;
  assign ap_start    = ap_start_reg;
  assign done_cnt    = done_cnt_reg;

  // Start sequencer: one HOLD cycle, START_DELAY WAIT cycles, then RUN forever.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= HOLD;
      wait_cnt_reg <= '0;
      ap_start_reg <= 1'b0;
    end else begin
      case (state_reg)
        HOLD: begin
          state_reg    <= WAIT;
          wait_cnt_reg <= WAIT_BITS'(1);
        end
        WAIT: begin
          if (wait_cnt_reg == WAIT_BITS'(START_DELAY)) begin
            state_reg    <= RUN;
            ap_start_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        RUN: begin
          ap_start_reg <= 1'b1;
        end
        default: begin
          state_reg    <= HOLD;
          ap_start_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;

  // Leaf -> kernel channels: FIFO plus delivered-word counter per channel.
  generate
    for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
      localparam int DLO = slice_lo(gi, PAYLOAD_BITS);
      localparam int CLO = slice_lo(gi, CNT_BITS);

      logic kernel_take;

      stream_fifo #(
        .WIDTH      (PAYLOAD_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
      ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .in_data  (if_dout[DLO +: PAYLOAD_BITS]),
        .in_vld   (if_vld[gi] & leaf_open),
        .in_ack   (in_fifo_ack[gi]),
        .out_data (usr_din[DLO +: PAYLOAD_BITS]),
        .out_vld  (in_fifo_vld[gi]),
        .out_ack  (usr_ack[gi] & kernel_open)
      );

      assign if_ack[gi]  = in_fifo_ack[gi] & leaf_open;
      assign usr_vld[gi] = in_fifo_vld[gi] & kernel_open;
      assign kernel_take = usr_vld[gi] & usr_ack[gi];
      assign in_cnt[CLO +: CNT_BITS] = in_cnt_reg[gi];

      // Count words handed to the kernel; resend clears, overriding the increment.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          in_cnt_reg[gi] <= '0;
        end else if (resend) begin
          in_cnt_reg[gi] <= '0;
        end else if (kernel_take) begin
          in_cnt_reg[gi] <= in_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // Kernel -> leaf channels: FIFO plus delivered-word counter per channel.
  generate
    for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
      localparam int DLO = slice_lo(gi, PAYLOAD_BITS);
      localparam int CLO = slice_lo(gi, CNT_BITS);

      logic leaf_take;

      stream_fifo #(
        .WIDTH      (PAYLOAD_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
      ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .in_data  (usr_dout[DLO +: PAYLOAD_BITS]),
        .in_vld   (usr_out_vld[gi] & kernel_open),
        .in_ack   (out_fifo_ack[gi]),
        .out_data (if_din[DLO +: PAYLOAD_BITS]),
        .out_vld  (if_out_vld[gi]),
        .out_ack  (if_out_ack[gi])
      );

      assign usr_out_ack[gi] = out_fifo_ack[gi] & kernel_open;
      assign leaf_take       = if_out_vld[gi] & if_out_ack[gi];
      assign out_cnt[CLO +: CNT_BITS] = out_cnt_reg[gi];

      // Count words handed to the leaf; resend clears, overriding the increment.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_cnt_reg[gi] <= '0;
        end else if (resend) begin
          out_cnt_reg[gi] <= '0;
        end else if (leaf_take) begin
          out_cnt_reg[gi] <= out_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // Count ap_done cycles regardless of sequencer state; resend clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_cnt_reg <= '0;
    end else if (resend) begin
      done_cnt_reg <= '0;
    end else if (ap_done) begin
      done_cnt_reg <= done_cnt_reg + 1'b1;
    end
  end

endmodule
